fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle datapath's decode/execute.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs in a small in-order ring, and presents them downstream through a valid/ready handshake.
- Branch/jump redirects from the datapath flush the ring and discard in-flight responses.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_buffer.sv | 83 ++++++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and ring entry type for the fetch stage
package fetch_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] data;
        logic                    filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - request, response, downstream and redirect signals of the fetch stage
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst_pc, inst_data,
        input  req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  req_valid, req_addr, inst_valid, inst_pc, inst_data,
        output req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order ring of {pc, data, filled} with alloc/fill/pop pointers and flush
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      alloc_en,
    input  logic [XLEN_DEFAULT-1:0]   alloc_pc,
    input  logic                      fill_en,
    input  logic [XLEN_DEFAULT-1:0]   fill_data,
    input  logic                      pop_en,
    output fetch_entry_t              head,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    pend
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, head_ptr_q, head_ptr_d;
    logic [CW-1:0] count_q, count_d, pend_q, pend_d;

    always_comb begin
        mem_d       = mem_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        pend_d      = pend_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i].filled = 1'b0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            pend_d      = '0;
        end else begin
            // Pop clears first; alloc never targets the head of a non-empty ring.
            if (pop_en) begin
                mem_d[head_ptr_q].filled = 1'b0;
                head_ptr_d = head_ptr_q + PW'(1);
            end
            if (alloc_en) begin
                mem_d[alloc_ptr_q].pc     = alloc_pc;
                mem_d[alloc_ptr_q].filled = 1'b0;
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (fill_en) begin
                mem_d[fill_ptr_q].data   = fill_data;
                mem_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d = fill_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(alloc_en) - CW'(pop_en);
            pend_d  = pend_q + CW'(alloc_en) - CW'(fill_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            pend_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
        end
    end

    assign head  = mem_q[head_ptr_q];
    assign count = count_q;
    assign pend  = pend_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, memory request issue, stale-response drop counter and ring wiring
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    fetch_entry_t    head;
    logic [CW-1:0]   count, pend;
    logic [SW-1:0]   inflight, owed;
    logic            req_fire, pop_fire, fill_en, rsp_drop;
    logic            unused_redirect_lo;

    assign unused_redirect_lo = ^bus.redirect_pc[1:0];
    // Ring occupancy plus owed drops bounds transactions outstanding at memory.
    assign inflight = SW'(count) + SW'(drop_cnt_q);
    assign owed     = SW'(pend) + SW'(drop_cnt_q);

    always_comb begin
        bus.req_valid  = reset && !bus.redirect_valid && (inflight < SW'(DEPTH));
        bus.req_addr   = fetch_pc_q;
        bus.inst_valid = head.filled && (count != '0) && !bus.redirect_valid;
        bus.inst_pc    = head.pc;
        bus.inst_data  = head.data;
    end

    assign req_fire = bus.req_valid && bus.req_ready;
    assign pop_fire = bus.inst_valid && bus.inst_ready;
    assign rsp_drop = bus.rsp_valid && (drop_cnt_q != '0);
    assign fill_en  = bus.rsp_valid && !bus.redirect_valid && (drop_cnt_q == '0) && (pend != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            // A response arriving with the redirect settles one owed transaction now.
            drop_cnt_d = (bus.rsp_valid && owed != '0) ? CW'(owed - SW'(1)) : CW'(owed);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (bus.redirect_valid),
        .alloc_en  (req_fire),
        .alloc_pc  (fetch_pc_q),
        .fill_en   (fill_en),
        .fill_data (bus.rsp_data),
        .pop_en    (pop_fire),
        .head      (head),
        .count     (count),
        .pend      (pend)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with an in-order variable-latency memory
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          tests = 0, failed = 0;
    int          cyc, lat, last_due, pops, nreq, first_pop_cyc, n0;
    logic [31:0] salt, exp_req, exp_pop, last_pop_pc, first_pop_pc, last_req_addr, prev_addr;
    logic        prev_stall;
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, sample at negedge, update the model, advance.
    task automatic tick();
        int d;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = memf(mq[0].addr);
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = $urandom;
        end
        @(negedge clk);
        s_req_valid  = bus.req_valid;
        s_req_addr   = bus.req_addr;
        s_inst_valid = bus.inst_valid;
        if (bus.redirect_valid) begin
            check("redir_req_valid", 32'(bus.req_valid), 32'd0);
            check("redir_inst_valid", 32'(bus.inst_valid), 32'd0);
        end
        if (prev_stall && !bus.redirect_valid) begin
            check("stall_hold_valid", 32'(bus.req_valid), 32'd1);
            check("stall_hold_addr", bus.req_addr, prev_addr);
        end
        if (bus.req_valid && bus.req_ready) begin
            check("req_addr", bus.req_addr, exp_req);
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: bus.req_addr, due: d});
            check("mem_outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
            exp_req       = exp_req + 32'd4;
            last_req_addr = bus.req_addr;
            nreq++;
        end
        if (bus.rsp_valid) void'(mq.pop_front());
        if (bus.inst_valid && bus.inst_ready) begin
            check("pop_pc", bus.inst_pc, exp_pop);
            check("pop_data", bus.inst_data, memf(exp_pop));
            if (first_pop_cyc < 0) begin
                first_pop_cyc = cyc;
                first_pop_pc  = bus.inst_pc;
            end
            last_pop_pc = bus.inst_pc;
            exp_pop     = exp_pop + 32'd4;
            pops++;
        end
        if (bus.redirect_valid) begin
            exp_req = {bus.redirect_pc[31:2], 2'b00};
            exp_pop = {bus.redirect_pc[31:2], 2'b00};
        end
        prev_stall = bus.req_valid && !bus.req_ready;
        prev_addr  = bus.req_addr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        exp_req = RESET_PC;
        exp_pop = RESET_PC;
        first_pop_cyc = -1;
        first_pop_pc = '0;
        pops = 0;
        nreq = 0;
        prev_stall = 1'b0;
        last_due = -1;
        cyc = 0;
        reset = 1'b1;
    endtask

    initial begin
        salt = $urandom | 32'h1;
        lat = 1;
        reset = 1'b0;
        bus.req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data = '0;
        #3;
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_req_addr", bus.req_addr, RESET_PC);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);

        // Streaming at latency 1: two-cycle startup, then one instruction per cycle.
        do_reset();
        lat = 1; bus.req_ready = 1'b1; bus.inst_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k >= 2) check("a_stream_valid", 32'(s_inst_valid), 32'd1);
        end
        check("a_first_pop_cyc", 32'(first_pop_cyc), 32'd2);
        check("a_first_pop_pc", first_pop_pc, 32'h0);
        check("a_pops", 32'(pops), 32'd10);

        // Downstream stalled: ring fills with four requests, then the request stops.
        do_reset();
        lat = 1; bus.req_ready = 1'b1; bus.inst_ready = 1'b0;
        repeat (8) tick();
        check("b_nreq", 32'(nreq), 32'd4);
        check("b_last_req", last_req_addr, 32'hC);
        check("b_req_valid_full", 32'(s_req_valid), 32'd0);
        bus.inst_ready = 1'b1;
        tick();
        check("b_pop_count", 32'(pops), 32'd1);
        check("b_pop_pc", last_pop_pc, 32'h0);
        n0 = nreq;
        for (int k = 0; k < 5 && nreq == n0; k++) tick();
        check("b_next_req", last_req_addr, 32'h10);

        // Latency 3, redirect with three outstanding; stale responses must be dropped.
        do_reset();
        lat = 3; bus.req_ready = 1'b1; bus.inst_ready = 1'b1;
        repeat (3) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("c_req_valid", 32'(s_req_valid), 32'd1);
        check("c_req_addr", s_req_addr, 32'h100);
        for (int k = 0; k < 20 && pops == 0; k++) tick();
        check("c_popped", 32'(pops), 32'd1);
        check("c_first_pc", first_pop_pc, 32'h100);

        // Redirect alongside a response with filled entries and inst_ready high; target wraps PC.
        do_reset();
        lat = 1; bus.req_ready = 1'b1; bus.inst_ready = 1'b1;
        repeat (6) tick();
        n0 = pops;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFA;
        tick();
        check("d_no_pop", 32'(pops), 32'(n0));
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 10 && pops == n0; k++) tick();
        check("d_first_pc", last_pop_pc, 32'hFFFF_FFF8);
        repeat (4) tick();

        // req_ready stuck low: address holds; a redirect withdraws it.
        do_reset();
        lat = 1; bus.req_ready = 1'b1; bus.inst_ready = 1'b0;
        repeat (2) tick();
        bus.req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("e_stuck_valid", 32'(s_req_valid), 32'd1);
            check("e_stuck_addr", s_req_addr, 32'h8);
        end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("e_after_valid", 32'(s_req_valid), 32'd1);
        check("e_after_addr", s_req_addr, 32'h40);

        // Asynchronous reset mid-stream with two filled entries.
        do_reset();
        lat = 1; bus.req_ready = 1'b1; bus.inst_ready = 1'b0;
        repeat (2) tick();
        bus.req_ready = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b0;
        #1;
        check("f_req_valid", 32'(bus.req_valid), 32'd0);
        check("f_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("f_req_addr", bus.req_addr, RESET_PC);
        check("f_inst_pc", bus.inst_pc, 32'd0);
        check("f_inst_data", bus.inst_data, 32'd0);
        do_reset();
        bus.req_ready = 1'b1; bus.inst_ready = 1'b1;
        tick();
        check("f_no_stale0", 32'(s_inst_valid), 32'd0);
        tick();
        check("f_no_stale1", 32'(s_inst_valid), 32'd0);
        for (int k = 0; k < 10 && pops == 0; k++) tick();
        check("f_first_pc", first_pop_pc, RESET_PC);

        // Randomized traffic against the program-order model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bus.req_ready      = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = $urandom;
            lat                = $urandom_range(1, 4);
            tick();
        end
        check("r_made_progress", 32'(pops > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
